// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signal bundle for memory_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface memory_arbiter_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    logic             p0_req;
    logic             p1_req;
    logic             p0_we;
    logic             p1_we;
    logic             p0_lock;
    logic             p1_lock;
    logic [DEPTH-1:0] p0_addr;
    logic [DEPTH-1:0] p1_addr;
    logic [WIDTH-1:0] p0_wdata;
    logic [WIDTH-1:0] p1_wdata;
    logic             p0_gnt;
    logic             p1_gnt;
    logic             p0_rvalid;
    logic             p1_rvalid;
    logic [WIDTH-1:0] p0_rdata;
    logic [WIDTH-1:0] p1_rdata;
    logic             mem_enable;
    logic             mem_wr_enable;
    logic [DEPTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wr_data;
    logic [WIDTH-1:0] mem_rd_data;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
        input  p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rd_data,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
        output mem_enable, mem_wr_enable, mem_address, mem_wr_data
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
        output p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rd_data,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
        input  mem_enable, mem_wr_enable, mem_address, mem_wr_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory (1-cycle read latency).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 0.
module memory_arbiter #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            resetn,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e           r_owner;
    owner_e           w_owner_next;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_winner;
    logic             w_sel_we;
    logic             w_sel_lock;
    logic [DEPTH-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;
    logic             r_mem_enable;
    logic             r_mem_wr_enable;
    logic [DEPTH-1:0] r_mem_address;
    logic [WIDTH-1:0] r_mem_wr_data;
    logic             r_tag1_valid;
    logic             r_tag1_port;
    logic             r_tag2_valid;
    logic             r_tag2_port;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic             r_rr_ptr;
`endif

    // Grant selection; grants are forced low while reset is held
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!resetn) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if ((r_owner == OWN_P0) && bus.p0_req) begin
            w_gnt0 = 1'b1;
        end else if ((r_owner == OWN_P1) && bus.p1_req) begin
            w_gnt1 = 1'b1;
        end else if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_gnt0 = ~r_rr_ptr;
            w_gnt1 = r_rr_ptr;
`else
            w_gnt0 = 1'b1;
            w_gnt1 = 1'b0;
`endif
        end else begin
            w_gnt0 = bus.p0_req;
            w_gnt1 = bus.p1_req;
        end
    end

    assign w_accept    = w_gnt0 | w_gnt1;
    assign w_winner    = w_gnt1;
    assign w_sel_we    = w_winner ? bus.p1_we    : bus.p0_we;
    assign w_sel_lock  = w_winner ? bus.p1_lock  : bus.p0_lock;
    assign w_sel_addr  = w_winner ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_winner ? bus.p1_wdata : bus.p0_wdata;

    // Ownership next state: only a locked accept keeps the bus, anything else releases it
    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_accept && w_sel_lock) begin
            w_owner_next = w_winner ? OWN_P1 : OWN_P0;
        end else begin
            w_owner_next = OWN_NONE;
        end
    end

    // Ownership state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // Registered memory drive; address and write data hold when idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_enable    <= 1'b0;
            r_mem_wr_enable <= 1'b0;
            r_mem_address   <= {DEPTH{1'b0}};
            r_mem_wr_data   <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_mem_enable    <= 1'b1;
            r_mem_wr_enable <= w_sel_we;
            r_mem_address   <= w_sel_addr;
            r_mem_wr_data   <= w_sel_wdata;
        end else begin
            r_mem_enable    <= 1'b0;
            r_mem_wr_enable <= 1'b0;
        end
    end

    // Read-return tag pipe: stage 1 tracks the memory access, stage 2 the data return
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag1_valid <= 1'b0;
            r_tag1_port  <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_port  <= 1'b0;
        end else begin
            r_tag1_valid <= w_accept & ~w_sel_we;
            r_tag1_port  <= w_winner;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_port  <= r_tag1_port;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin pointer favours the loser of the most recent accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_winner;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    assign bus.p0_gnt        = w_gnt0;
    assign bus.p1_gnt        = w_gnt1;
    assign bus.p0_rvalid     = r_tag2_valid & ~r_tag2_port;
    assign bus.p1_rvalid     = r_tag2_valid & r_tag2_port;
    assign bus.p0_rdata      = bus.mem_rd_data;
    assign bus.p1_rdata      = bus.mem_rd_data;
    assign bus.mem_enable    = r_mem_enable;
    assign bus.mem_wr_enable = r_mem_wr_enable;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_wr_data   = r_mem_wr_data;
endmodule
